// File: rtl/ad9625_capture_pkg.sv
// ad9625_capture_pkg: shared types and default sizes for the AD9625
// capture buffer (FSM state encoding, widths, FIFO entry width).
package ad9625_capture_pkg;

    localparam int DEF_DATA_WIDTH      = 256;
    localparam int DEF_FIFO_ADDR_WIDTH = 5;
    localparam int DEF_LENGTH_WIDTH    = 16;

    // A FIFO entry carries the sample beat plus the last-beat flag.
    function automatic int entry_width(int data_width);
        return data_width + 1;
    endfunction

    localparam int ENTRY_WIDTH = entry_width(DEF_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } cap_state_t;

endpackage

// File: rtl/ad9625_capture_fifo.sv
// ad9625_capture_fifo: single-clock show-ahead FIFO with a registered
// output stage, full/empty flags and an occupancy count.
// Ports: clk, rst (sync, active-high); wr_en/wr_data write side (a write
// while full is ignored); rd_en pops the head when rd_valid is high;
// rd_valid/rd_data registered head; full, empty, level occupancy.
module ad9625_capture_fifo #(
    parameter int WIDTH      = ad9625_capture_pkg::ENTRY_WIDTH,
    parameter int ADDR_WIDTH = ad9625_capture_pkg::DEF_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   occ;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  push;
    logic                  pop;
    logic                  load;

    // occ counts the output register too, so the whole FIFO holds DEPTH.
    assign full      = (occ == DEPTH_V);
    assign empty     = (occ == '0);
    assign level     = occ;
    assign mem_count = occ - (ADDR_WIDTH + 1)'(out_valid);
    assign push      = wr_en && !full;
    assign pop       = rd_en && out_valid;
    assign load      = (mem_count != '0) && (!out_valid || pop);
    assign rd_valid  = out_valid;
    assign rd_data   = out_data;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            occ <= occ + (ADDR_WIDTH + 1)'(push)
                       - (ADDR_WIDTH + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            rd_ptr    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ad9625_capture.sv
// ad9625_capture: triggered capture of a programmed number of AD9625
// beats into a FIFO, streamed out with a last marker; adc_dovf flags drops.
// Ports: adc_clk, adc_rst (sync, active-high); adc_valid/adc_enable/
// adc_data input beats; capture_arm/capture_length/capture_trigger control;
// m_valid/m_ready/m_data/m_last output stream; adc_dovf, capture_busy,
// capture_done status. Define ADC_CAPTURE_TRIG_EN for triggered starts.
module ad9625_capture
    import ad9625_capture_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int FIFO_ADDR_WIDTH = DEF_FIFO_ADDR_WIDTH,
    parameter int LENGTH_WIDTH    = DEF_LENGTH_WIDTH
) (
    input  logic                    adc_clk,
    input  logic                    adc_rst,
    input  logic                    adc_valid,
    input  logic                    adc_enable,
    input  logic [DATA_WIDTH-1:0]   adc_data,
    input  logic                    capture_arm,
    input  logic [LENGTH_WIDTH-1:0] capture_length,
    input  logic                    capture_trigger,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_last,
    output logic                    adc_dovf,
    output logic                    capture_busy,
    output logic                    capture_done
);

    localparam int EW = entry_width(DATA_WIDTH);

    cap_state_t              state;
    cap_state_t              state_next;
    logic [LENGTH_WIDTH-1:0] len;
    logic [LENGTH_WIDTH-1:0] len_next;
    logic [LENGTH_WIDTH-1:0] cnt;
    logic [LENGTH_WIDTH-1:0] cnt_next;
    logic                    dovf_next;
    logic                    done_next;
    logic                    take;
    logic                    accepted;
    logic                    beat_last;
    logic                    fifo_wr;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_rd_valid;
    logic [EW-1:0]           fifo_rd_data;
    logic [FIFO_ADDR_WIDTH:0] unused_level;

    assign accepted = adc_valid && adc_enable;

`ifndef ADC_CAPTURE_TRIG_EN
    logic unused_trigger;
    assign unused_trigger = capture_trigger;
`endif

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state        <= IDLE;
            len          <= '0;
            cnt          <= '0;
            adc_dovf     <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            state        <= state_next;
            len          <= len_next;
            cnt          <= cnt_next;
            adc_dovf     <= dovf_next;
            capture_done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        len_next   = len;
        cnt_next   = cnt;
        dovf_next  = 1'b0;
        done_next  = 1'b0;
        take       = 1'b0;
        fifo_wr    = 1'b0;
        beat_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture_arm && capture_length != '0) begin
                    len_next = capture_length;
                    cnt_next = '0;
`ifdef ADC_CAPTURE_TRIG_EN
                    state_next = ARMED;
`else
                    state_next = CAPTURE;
`endif
                end
            end
            ARMED: begin
`ifdef ADC_CAPTURE_TRIG_EN
                // The triggering beat is beat 1 of the capture.
                take = accepted && capture_trigger;
`else
                state_next = IDLE;
`endif
            end
            CAPTURE: begin
                take = accepted;
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Dropped beats still count: duration follows input beats.
        if (take) begin
            cnt_next  = cnt + LENGTH_WIDTH'(1);
            beat_last = (cnt_next == len);
            if (fifo_full) begin
                dovf_next = 1'b1;
            end else begin
                fifo_wr = 1'b1;
            end
            state_next = beat_last ? DRAIN : CAPTURE;
        end
    end

    ad9625_capture_fifo #(
        .WIDTH      (EW),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk      (adc_clk),
        .rst      (adc_rst),
        .wr_en    (fifo_wr),
        .wr_data  ({beat_last, adc_data}),
        .rd_en    (m_ready),
        .rd_valid (fifo_rd_valid),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (unused_level)
    );

    assign m_valid      = fifo_rd_valid;
    assign m_data       = fifo_rd_data[DATA_WIDTH-1:0];
    assign m_last       = fifo_rd_data[DATA_WIDTH];
    assign capture_busy = (state != IDLE);

endmodule

// File: tb/tb_ad9625_capture.sv
// tb_ad9625_capture: self-checking bench for ad9625_capture using a
// table of capture scenarios, corner sequences and randomized captures.
module tb_ad9625_capture;

    localparam int DW    = 256;
    localparam int AW    = 5;
    localparam int LW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          adc_clk = 1'b0;
    logic          adc_rst = 1'b1;
    logic          adc_valid = 1'b0;
    logic          adc_enable = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          capture_arm = 1'b0;
    logic [LW-1:0] capture_length = '0;
    logic          capture_trigger = 1'b0;
    logic          m_ready = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          adc_dovf;
    logic          capture_busy;
    logic          capture_done;

    always #5 adc_clk = ~adc_clk;

    ad9625_capture #(
        .DATA_WIDTH      (DW),
        .FIFO_ADDR_WIDTH (AW),
        .LENGTH_WIDTH    (LW)
    ) dut (
        .adc_clk         (adc_clk),
        .adc_rst         (adc_rst),
        .adc_valid       (adc_valid),
        .adc_enable      (adc_enable),
        .adc_data        (adc_data),
        .capture_arm     (capture_arm),
        .capture_length  (capture_length),
        .capture_trigger (capture_trigger),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .adc_dovf        (adc_dovf),
        .capture_busy    (capture_busy),
        .capture_done    (capture_done)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t got_q[$];
    int    dovf_total = 0;
    int    done_total = 0;

    always @(negedge adc_clk) begin
        beat_t b;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            b.d = m_data;
            b.l = m_last;
            got_q.push_back(b);
        end
        if (adc_dovf === 1'b1) dovf_total++;
        if (capture_done === 1'b1) done_total++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic arm(input int len);
        capture_arm    = 1'b1;
        capture_length = LW'(len);
        cyc();
        capture_arm    = 1'b0;
    endtask

    function automatic logic [DW-1:0] mk(input int tag, input int i);
        return (DW'(tag) << 32) | DW'(i);
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic wait_done(input int dn0);
        int n;
        n = 0;
        while (done_total == dn0 && n < 400) begin
            cyc();
            n++;
        end
        cyc();
        cyc();
    endtask

    // Compare captured output from index q0 against the expected beats.
    task automatic check_out(input string nm, input int q0,
                             input logic [DW-1:0] exp_d[$],
                             input int exp_last, input int dv0,
                             input int exp_dovf, input int dn0);
        int n_out;
        int n_last;
        n_out  = got_q.size() - q0;
        n_last = 0;
        for (int k = q0; k < got_q.size(); k++)
            if (got_q[k].l) n_last++;
        chk({nm, " out_count"}, DW'(n_out), DW'(exp_d.size()));
        chk({nm, " dovf_count"}, DW'(dovf_total - dv0), DW'(exp_dovf));
        chk({nm, " last_count"}, DW'(n_last), DW'(exp_last));
        chk({nm, " done_count"}, DW'(done_total - dn0), DW'(1));
        chk({nm, " busy_end"}, DW'(capture_busy), DW'(0));
        for (int k = 0; k < n_out && k < exp_d.size(); k++)
            chk($sformatf("%s data[%0d]", nm, k), got_q[q0 + k].d, exp_d[k]);
        if (exp_last != 0 && n_out > 0)
            chk({nm, " last_pos"}, DW'(got_q[got_q.size() - 1].l), DW'(1));
    endtask

    typedef struct {
        int          len;
        int          beats;
        logic [15:0] en;
        bit          rdy;
        int          exp_dovf;
        int          exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input string nm);
        int            q0, dv0, dn0, acc, stored;
        logic [DW-1:0] exp_d[$];
        q0  = got_q.size();
        dv0 = dovf_total;
        dn0 = done_total;
        m_ready         = v.rdy;
        capture_trigger = 1'b1;
        arm(v.len);
        // With the sink stalled only DEPTH beats fit; otherwise all fit.
        stored = v.rdy ? v.len : (v.len < DEPTH ? v.len : DEPTH);
        acc = 0;
        for (int i = 0; i < v.beats; i++) begin
            adc_valid  = 1'b1;
            adc_enable = v.en[i % 16];
            adc_data   = mk(v.len, i);
            if (adc_enable) begin
                if (acc < stored) exp_d.push_back(adc_data);
                acc++;
            end
            cyc();
        end
        adc_valid  = 1'b0;
        adc_enable = 1'b0;
        m_ready    = 1'b1;
        wait_done(dn0);
        check_out(nm, q0, exp_d, v.exp_last, dv0, v.exp_dovf, dn0);
    endtask

    task automatic run_random(input int it);
        int            q0, dv0, dn0, len, acc, n;
        logic [DW-1:0] exp_d[$];
        q0  = got_q.size();
        dv0 = dovf_total;
        dn0 = done_total;
        len = int'($urandom_range(1, DEPTH));
        capture_trigger = 1'b1;
        m_ready = 1'($urandom_range(0, 1));
        arm(len);
        acc = 0;
        n   = 0;
        while (acc < len && n < 500) begin
            adc_valid  = 1'($urandom_range(0, 1));
            adc_enable = ($urandom_range(0, 3) != 0);
            adc_data   = rnd_word();
            m_ready    = 1'($urandom_range(0, 1));
            if (adc_valid && adc_enable) begin
                exp_d.push_back(adc_data);
                acc++;
            end
            cyc();
            n++;
        end
        adc_valid = 1'b0;
        m_ready   = 1'b1;
        wait_done(dn0);
        check_out($sformatf("rand%0d", it), q0, exp_d, 1, dv0, 0, dn0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            q0, dv0, dn0;
        logic [DW-1:0] exp_d[$];

        vecs[0] = '{len: 8,  beats: 16, en: 16'hFFFF, rdy: 1'b1,
                    exp_dovf: 0, exp_last: 1};
        vecs[1] = '{len: 4,  beats: 16, en: 16'h5555, rdy: 1'b1,
                    exp_dovf: 0, exp_last: 1};
        vecs[2] = '{len: 40, beats: 48, en: 16'hFFFF, rdy: 1'b0,
                    exp_dovf: 8, exp_last: 0};
        vecs[3] = '{len: 32, beats: 40, en: 16'hFFFF, rdy: 1'b0,
                    exp_dovf: 0, exp_last: 1};
        vecs[4] = '{len: 33, beats: 40, en: 16'hFFFF, rdy: 1'b0,
                    exp_dovf: 1, exp_last: 0};
        vecs[5] = '{len: 1,  beats: 4,  en: 16'hFFFF, rdy: 1'b1,
                    exp_dovf: 0, exp_last: 1};

        repeat (3) cyc();
        chk("rst m_valid", DW'(m_valid), DW'(0));
        chk("rst m_data", m_data, '0);
        chk("rst m_last", DW'(m_last), DW'(0));
        chk("rst adc_dovf", DW'(adc_dovf), DW'(0));
        chk("rst busy", DW'(capture_busy), DW'(0));
        chk("rst done", DW'(capture_done), DW'(0));
        adc_rst = 1'b0;
        cyc();

        for (int v = 0; v < 6; v++)
            run_vec(vecs[v], $sformatf("vec%0d", v));

        // Zero-length arm is ignored.
        dn0 = done_total;
        arm(0);
        chk("len0 busy_a", DW'(capture_busy), DW'(0));
        cyc();
        chk("len0 busy_b", DW'(capture_busy), DW'(0));
        chk("len0 done", DW'(done_total - dn0), DW'(0));

        // Re-arm during capture must not change the length.
        q0 = got_q.size(); dv0 = dovf_total; dn0 = done_total;
        exp_d = {};
        m_ready = 1'b1;
        arm(4);
        chk("rearm busy", DW'(capture_busy), DW'(1));
        for (int i = 0; i < 8; i++) begin
            adc_valid   = 1'b1;
            adc_enable  = 1'b1;
            adc_data    = mk(77, i);
            capture_arm = (i == 2);
            capture_length = LW'(9);
            if (i < 4) exp_d.push_back(adc_data);
            cyc();
        end
        capture_arm = 1'b0;
        adc_valid   = 1'b0;
        wait_done(dn0);
        check_out("rearm", q0, exp_d, 1, dv0, 0, dn0);

        // Trigger qualifies the start beat only in the triggered build.
        q0 = got_q.size(); dv0 = dovf_total; dn0 = done_total;
        exp_d = {};
        arm(2);
        for (int i = 0; i < 8; i++) begin
            adc_valid  = 1'b1;
            adc_enable = 1'b1;
`ifdef ADC_CAPTURE_TRIG_EN
            capture_trigger = (i == 4);
            adc_data = (i == 4) ? DW'('h55) : DW'('h10 + i);
            if (i == 4 || i == 5) exp_d.push_back(adc_data);
`else
            capture_trigger = 1'b0;
            adc_data = DW'('hA1 + i);
            if (i < 2) exp_d.push_back(adc_data);
`endif
            cyc();
        end
        adc_valid = 1'b0;
        capture_trigger = 1'b1;
        wait_done(dn0);
        check_out("trig", q0, exp_d, 1, dv0, 0, dn0);

        // Reset with entries buffered discards them without a done pulse.
        dn0 = done_total;
        m_ready = 1'b0;
        arm(20);
        for (int i = 0; i < 10; i++) begin
            adc_valid  = 1'b1;
            adc_enable = 1'b1;
            adc_data   = mk(99, i);
            cyc();
        end
        adc_valid = 1'b0;
        cyc();
        chk("rstmid pre m_valid", DW'(m_valid), DW'(1));
        chk("rstmid pre busy", DW'(capture_busy), DW'(1));
        adc_rst = 1'b1;
        cyc();
        chk("rstmid m_valid", DW'(m_valid), DW'(0));
        chk("rstmid busy", DW'(capture_busy), DW'(0));
        adc_rst = 1'b0;
        m_ready = 1'b1;
        cyc();
        cyc();
        chk("rstmid m_valid_after", DW'(m_valid), DW'(0));
        chk("rstmid no_done", DW'(done_total - dn0), DW'(0));
        run_vec(vecs[0], "post_rst");

        for (int it = 0; it < 10; it++) run_random(it);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad9625_capture.md
# ad9625_capture

Triggered capture buffer directly downstream of the AD9625 core, in the `adc_clk` domain. It takes the formatted 256-bit sample stream (`adc_valid`/`adc_enable`/`adc_data`) and captures a programmed number of beats into a small FIFO. It presents those beats to the DMA on a valid/ready stream with a last marker. It also generates `adc_dovf`, the overflow indication the core's common register bank reports.

## Interface
- DATA_WIDTH, 256, sample beat width.
- FIFO_ADDR_WIDTH, 5, FIFO depth = 2^FIFO_ADDR_WIDTH entries.
- LENGTH_WIDTH, 16, width of the capture length.
- adc_clk  in  1  sole clock; one clock, all logic on rising edge.
- adc_rst  in  1  reset, synchronous, active-high.
- adc_valid  in  1  input beat qualifier.
- adc_enable  in  1  channel enable; beats with adc_enable=0 are ignored.
- adc_data  in  DATA_WIDTH  input beat.
- capture_arm  in  1  single-cycle start request.
- capture_length  in  LENGTH_WIDTH  beats per capture, sampled on arm.
- capture_trigger  in  1  start-of-capture qualifier; used only with the trigger macro.
- m_valid  out  1  output beat valid.
- m_ready  in  1  DMA accept.
- m_data  out  DATA_WIDTH  output beat.
- m_last  out  1  final beat of the capture.
- adc_dovf  out  1  one-cycle pulse per dropped beat.
- capture_busy  out  1  high in any state other than IDLE.
- capture_done  out  1  one-cycle pulse on return to IDLE.

## Operation
- An accepted beat is one with adc_valid & adc_enable both high.
- FSM states: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE:
  - capture_arm with capture_length != 0 latches the length and clears the beat counter.
  - Goes to ARMED with the trigger macro, CAPTURE without it.
  - Arm with length 0 is ignored.
- ARMED: the first accepted beat with capture_trigger=1 is beat 1 of the capture and is processed as in CAPTURE in the same cycle.
- CAPTURE:
  - Every accepted beat increments the counter.
  - If the FIFO is not full, the beat is written together with a last flag. last = (counter == length).
  - If the FIFO is full, the beat is dropped, adc_dovf pulses, and the counter still increments. Capture duration is bounded by input beats, not by stored beats.
- Leaving CAPTURE: when the counter reaches length, go to DRAIN.
- DRAIN: once the FIFO is empty, go to IDLE and pulse capture_done in the same edge.
- If the final beat is dropped, no m_last is produced for that capture. capture_done still pulses.
- capture_arm outside IDLE is ignored.
- Output side: FIFO read on m_valid & m_ready. m_data/m_last hold while m_valid & !m_ready.
- Width rules:
  - Counter is LENGTH_WIDTH bits and never wraps, because length is at most 2^LENGTH_WIDTH-1.
  - FIFO occupancy counter is FIFO_ADDR_WIDTH+1 bits.
  - Read/write pointers wrap modulo depth.

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0, adc_dovf=0, capture_busy=0, capture_done=0. FSM is in IDLE and the FIFO is empty.
- Reset mid-capture discards FIFO contents on the next edge. No capture_done is generated.
- Latency: a beat written at edge N shows m_valid=1 after edge N+1 if the FIFO was empty.
- Throughput: one beat per cycle with m_ready held high.
- Full is evaluated on occupancy before the current cycle's read. A write when full with a simultaneous read is still dropped.
- adc_dovf is registered: it is high for the cycle after the dropped beat's edge.
- capture_busy goes high the edge after arm. It goes low the same edge capture_done goes high.

## Configuration
- ADC_CAPTURE_TRIG_EN defined: ARMED state present; capture starts on the first accepted beat with capture_trigger=1.
- ADC_CAPTURE_TRIG_EN undefined:
  - ARMED and capture_trigger logic are removed; capture_trigger is left unconnected internally.
  - Arm goes directly to CAPTURE, and the first accepted beat after the arm edge is beat 1.

## Structure
- Package ad9625_capture_pkg holds:
  - FSM state enum (IDLE, ARMED, CAPTURE, DRAIN).
  - Default width constants.
  - The FIFO entry width constant (DATA_WIDTH+1 for the last flag).
- Sub-module ad9625_capture_fifo: single-clock show-ahead FIFO with registered output, full/empty flags and an occupancy count. Reset is synchronous, active-high.

## Test plan
- Length 8, m_ready=1, continuous beats 0..15 → m_data 0..7, m_last on 7, capture_done one cycle after beat 7 drains, 0 adc_dovf.
- Depth 32, length 40, m_ready=0 throughout capture → 32 stored, 8 adc_dovf pulses, no m_last. Then m_ready=1 → 32 beats out, capture_done.
- Trigger macro on, arm, trigger high on 5th beat (data 0x55) → first m_data=0x55. Macro off → first beat after arm is captured.
- adc_enable toggling 1,0,1,0 with length 4 → only enabled beats stored, last on the 4th enabled beat.
- Arm with length 0 → capture_busy stays 0. Arm during CAPTURE → ignored, count unchanged.
- adc_rst asserted mid-capture with 10 entries → next cycle m_valid=0 and busy=0. A new arm then works normally.
